// File: rtl/bsg_link_downstream_param.sv
// Receive side of the source-synchronous link: registers IO flits, packs them
// little-endian into core words, buffers them in a FWFT FIFO, and returns decimated credit.
module bsg_link_downstream_param #(
   parameter int IO_W        = 32'd8,
   parameter int CORE_W      = 32'd32,
   parameter int DEPTH       = 32'd64,
   parameter int TOKEN_DECIM = 32'd8,
   localparam int PTR_W      = $clog2(DEPTH) + 32'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_valid_in,
   input  logic [IO_W-1:0]   io_data_in,
   input  logic              core_ready,
   output logic              core_valid_out,
   output logic [CORE_W-1:0] core_data_out,
   output logic              io_token_out,
   output logic [PTR_W-1:0]  occupancy,
   output logic              overflow_err
);

   localparam int R   = CORE_W / IO_W;
   localparam int GW  = (R > 32'd1) ? $clog2(R) : 32'd1;
   localparam int TCW = (TOKEN_DECIM > 32'd1) ? $clog2(TOKEN_DECIM) : 32'd1;
   localparam int AW  = PTR_W - 32'd1;

   logic              io_valid_q, io_valid_d;
   logic [IO_W-1:0]   io_data_q, io_data_d;
   logic [GW-1:0]     gear_q, gear_d;
   logic [CORE_W-1:0] part_q, part_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [TCW-1:0]    tcnt_q, tcnt_d;
   logic              token_q, token_d;
   logic              ovf_q, ovf_d;

   logic [CORE_W-1:0] word_s;
   logic              done_s;
   logic              empty_s;
   logic              full_s;
   logic              deq_s;
   logic              wr_s;

   logic [CORE_W-1:0] mem [DEPTH];

   // Gearbox: the current flit overlays its slot of the partial word, forming the write candidate.
   always_comb begin
      io_valid_d = io_valid_in;
      io_data_d  = io_data_in;
      word_s     = part_q;
      for (int i = 0; i < R; i++) begin
         if (gear_q == GW'(i)) begin
            word_s[i*IO_W +: IO_W] = io_data_q;
         end else begin
            word_s[i*IO_W +: IO_W] = part_q[i*IO_W +: IO_W];
         end
      end
      done_s = io_valid_q && (gear_q == GW'(R - 1));
      if (io_valid_q) begin
         part_d = word_s;
         if (done_s) begin
            gear_d = {GW{1'b0}};
         end else begin
            gear_d = gear_q + GW'(1);
         end
      end else begin
         part_d = part_q;
         gear_d = gear_q;
      end
   end

   // FIFO control: a full FIFO still accepts a word when the head leaves in the same cycle.
   always_comb begin
      empty_s = (rptr_q == wptr_q);
      full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      deq_s   = !empty_s && core_ready;
      wr_s    = done_s && (!full_s || deq_s);
      if (wr_s) begin
         wptr_d = wptr_q + PTR_W'(1);
      end else begin
         wptr_d = wptr_q;
      end
      if (deq_s) begin
         rptr_d = rptr_q + PTR_W'(1);
      end else begin
         rptr_d = rptr_q;
      end
      if (done_s && !wr_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Credit return: one pulse per TOKEN_DECIM dequeues.
   always_comb begin
      tcnt_d  = tcnt_q;
      token_d = 1'b0;
      if (deq_s) begin
         if (tcnt_q == TCW'(TOKEN_DECIM - 1)) begin
            tcnt_d  = {TCW{1'b0}};
            token_d = 1'b1;
         end else begin
            tcnt_d  = tcnt_q + TCW'(1);
            token_d = 1'b0;
         end
      end else begin
         tcnt_d  = tcnt_q;
         token_d = 1'b0;
      end
   end

   // State registers; reset drops any partial word and in-flight flit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_valid_q <= 1'b0;
         io_data_q  <= {IO_W{1'b0}};
         gear_q     <= {GW{1'b0}};
         part_q     <= {CORE_W{1'b0}};
         wptr_q     <= {PTR_W{1'b0}};
         rptr_q     <= {PTR_W{1'b0}};
         tcnt_q     <= {TCW{1'b0}};
         token_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         io_valid_q <= io_valid_d;
         io_data_q  <= io_data_d;
         gear_q     <= gear_d;
         part_q     <= part_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         tcnt_q     <= tcnt_d;
         token_q    <= token_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage array, deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem[wptr_q[AW-1:0]] <= word_s;
      end
   end

   assign core_valid_out = !empty_s;
   assign core_data_out  = mem[rptr_q[AW-1:0]];
   assign occupancy      = wptr_q - rptr_q;
   assign io_token_out   = token_q;
   assign overflow_err   = ovf_q;

endmodule

// File: doc/bsg_link_downstream_param.md
Name: bsg_link_downstream_param

Overview:
- Parametrised receive side of the source-synchronous link channel.
- Registers narrow IO flits and packs R = CORE_W/IO_W flits into one core word, little-endian.
- Buffers words in a DEPTH-entry FIFO presented to the core with valid/ready.
- Returns credit to the upstream sender as decimated token pulses, one per TOKEN_DECIM words consumed.
- Successor to the fixed 8-bit/32-bit single-token channel: width ratio, depth and token decimation are configurable, and it adds occupancy and overflow reporting.

Parameters:
IO_W, 8, IO flit width in bits
CORE_W, 32, core word width; must be an integer multiple of IO_W (R = CORE_W/IO_W, R >= 1)
DEPTH, 64, FIFO entries; power of two, >= 2
TOKEN_DECIM, 8, dequeued words per io_token_out pulse; 1 <= TOKEN_DECIM <= DEPTH
PTR_W, clog2(DEPTH)+1, pointer width (derived, not overridden)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-low reset
io_valid_in  in  1  flit valid from link
io_data_in  in  IO_W  flit data
core_ready  in  1  core accepts core_data_out this cycle
core_valid_out  out  1  FIFO non-empty
core_data_out  out  CORE_W  head-of-FIFO word
io_token_out  out  1  one-cycle credit pulse to upstream
occupancy  out  PTR_W  words currently stored (0..DEPTH)
overflow_err  out  1  sticky: a completed word arrived while FIFO full

Behaviour:
- Reset (rst=0, asynchronous, any cycle):
  - Clears io_valid/io_data input regs, gear count, partial word, rptr, wptr, token counter, io_token_out and overflow_err.
  - Partial word and any in-flight flit are discarded. Memory contents are not reset.
  - Outputs during reset: core_valid_out=0, io_token_out=0, occupancy=0, overflow_err=0; core_data_out don't-care.
- Input stage: io_valid <= io_valid_in; io_data <= io_data_in, every cycle.
- Gearbox:
  - On io_valid=1, io_data goes to bits [IO_W*(g+1)-1 : IO_W*g] of the word under assembly, where g is the gear count (0..R-1).
  - g increments and wraps from R-1 to 0. With R=1, every flit is a complete word.
  - The word completes when io_valid=1 and g=R-1; the completed word (including the current flit) is the write candidate.
- Write: a complete word is written at mem[wptr[PTR_W-2:0]] and wptr increments when !full, or when full and a dequeue occurs in the same cycle.
  - Otherwise the word is dropped, wptr holds, and overflow_err <= 1 (sticky until reset).
  - Upstream credit discipline makes overflow illegal; this is error reporting only.
- Flags:
  - empty = (rptr == wptr).
  - full = MSBs of the pointers differ and the remaining bits are equal.
  - occupancy = wptr - rptr, modulo 2^PTR_W.
  - Pointers wrap naturally at 2^PTR_W.
- Read (first-word-fall-through):
  - core_valid_out = !empty; core_data_out = mem[rptr[PTR_W-2:0]].
  - Dequeue when core_valid_out & core_ready; rptr increments.
  - core_ready while empty has no effect.
- Latency:
  - The last flit of a word, presented on io_valid_in before edge k, is registered at edge k and written at edge k+1.
  - core_valid_out is high after edge k+1.
  - There is no empty bypass: a write into an empty FIFO becomes visible the cycle after the write.
- Simultaneous write and dequeue: both take effect; occupancy is unchanged. When full, the freed slot is reused and no overflow is flagged.
- Tokens:
  - tcnt (0..TOKEN_DECIM-1) increments on each dequeue.
  - On a dequeue with tcnt = TOKEN_DECIM-1: tcnt <= 0 and io_token_out <= 1 for exactly one cycle. Otherwise io_token_out <= 0.
  - Back-to-back pulses are possible only when TOKEN_DECIM=1.
  - No tokens are issued at reset; the upstream starts with DEPTH credits.

Test Plan:
- Defaults except DEPTH=8, TOKEN_DECIM=4. Flits 0x11,0x22,0x33,0x44 on consecutive cycles, core_ready=0 -> core_valid_out rises 2 cycles after 0x44 is presented; core_data_out=0x44332211; occupancy=1.
- Eight words streamed with core_ready=0 -> occupancy=8 and full. A ninth word -> dropped, overflow_err=1, occupancy stays 8, and the head is still word 0.
- FIFO full; core_ready=1 held while a ninth word completes in the same cycle -> word accepted, overflow_err stays 0, occupancy stays 8.
- 20 words written and drained with core_ready=1, passing pointer wrap -> data returned in order, exactly 5 io_token_out single-cycle pulses, each on the cycle after the 4th, 8th, 12th, 16th and 20th dequeue.
- Reset asserted after 2 of 4 flits of a word with 3 words stored -> core_valid_out=0 and occupancy=0 immediately. After release, 4 new flits 0xA0..0xA3 -> core_data_out=0xA3A2A1A0.
- IO_W=8, CORE_W=8, TOKEN_DECIM=1, flit 0x5A with core_ready=1 -> core_data_out=0x5A for one cycle, then io_token_out pulses once on the following cycle.
